// File: rtl/rob_commit_unit.sv
// In-order retire stage behind the ROB: RF writeback, store release to memory,
// and misprediction/exception recovery followed by a fixed flush window.
module rob_commit_unit #(
  parameter int          ROBsize      = 16,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [63:0] EXC_VECTOR   = 64'h0000_0100,
  localparam int         addrSize     = $clog2(ROBsize)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [78:0]         commitReadData_i,
  input  logic [addrSize:0]   head_i,
  input  logic [63:0]         headExtra_i,
  output logic                updateHead_o,
  output logic                needToRestore_o,
  output logic                rfWriteEn_o,
  output logic [4:0]          rfWriteAddr_o,
  output logic [63:0]         rfWriteData_o,
  output logic [addrSize:0]   rfWriteTag_o,
  output logic                storeReq_o,
  output logic [63:0]         storeAddr_o,
  output logic [63:0]         storeData_o,
  input  logic                storeAck_i,
  output logic                redirect_o,
  output logic [63:0]         redirectPC_o,
  output logic [31:0]         retiredCount_o
);

  typedef enum logic [1:0] {RUN, STORE_WAIT, RESTORE, FLUSH} state_t;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        state;
  logic [FW-1:0] flush_cnt;

  logic        occupied, reg_write, is_store, is_branch, done, mispredict, exception;
  logic [4:0]  rd;
  logic [63:0] result;
  logic        unused_rsvd;

  assign occupied    = commitReadData_i[78];
  assign rd          = commitReadData_i[77:73];
  assign reg_write   = commitReadData_i[72];
  assign is_store    = commitReadData_i[71];
  assign is_branch   = commitReadData_i[70];
  assign done        = commitReadData_i[69];
  assign mispredict  = commitReadData_i[68];
  assign exception   = commitReadData_i[67];
  assign result      = commitReadData_i[63:0];
  assign unused_rsvd = ^commitReadData_i[66:64];

  logic ready, rf_ok, pop, wen, do_recover, do_store;
  assign ready = occupied & done;
  assign rf_ok = reg_write & (rd != 5'd0);

  // Exception outranks mispredict; stores hold the head until memory acks.
  always_comb begin
    pop        = 1'b0;
    wen        = 1'b0;
    do_recover = 1'b0;
    do_store   = 1'b0;
    if (!reset_i) begin
      case (state)
        RUN: if (ready) begin
          if (exception) begin
            pop        = 1'b1;
            do_recover = 1'b1;
          end else if (is_branch & mispredict) begin
            pop        = 1'b1;
            wen        = rf_ok;
            do_recover = 1'b1;
          end else if (is_store) begin
            do_store   = 1'b1;
          end else begin
            pop        = 1'b1;
            wen        = rf_ok;
          end
        end
        STORE_WAIT: pop = storeAck_i & occupied;
        default: ;
      endcase
    end
  end

  assign updateHead_o  = pop;
  assign rfWriteEn_o   = wen;
  assign rfWriteAddr_o = wen ? rd : 5'd0;
  assign rfWriteData_o = wen ? result : 64'd0;
  assign rfWriteTag_o  = pop ? head_i : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= RUN;
      flush_cnt       <= '0;
      storeReq_o      <= 1'b0;
      storeAddr_o     <= 64'd0;
      storeData_o     <= 64'd0;
      needToRestore_o <= 1'b0;
      redirect_o      <= 1'b0;
      redirectPC_o    <= 64'd0;
      retiredCount_o  <= 32'd0;
    end else begin
      if (pop) retiredCount_o <= retiredCount_o + 32'd1;
      needToRestore_o <= 1'b0;
      redirect_o      <= 1'b0;
      case (state)
        RUN: begin
          if (do_recover) begin
            state           <= RESTORE;
            needToRestore_o <= 1'b1;
            redirect_o      <= 1'b1;
            redirectPC_o    <= exception ? EXC_VECTOR : headExtra_i;
          end else if (do_store) begin
            state       <= STORE_WAIT;
            storeReq_o  <= 1'b1;
            storeAddr_o <= headExtra_i;
            storeData_o <= result;
          end
        end
        STORE_WAIT: if (storeAck_i) begin
          storeReq_o <= 1'b0;
          state      <= RUN;
        end
        RESTORE: begin
          state     <= FLUSH;
          flush_cnt <= '0;
        end
        FLUSH: begin
          if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state <= RUN;
          else flush_cnt <= flush_cnt + FW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
